ttl_decimal_keypad_encoder: RTL and testbench
=============================================

Name: ttl_decimal_keypad_encoder

Overview:
- Clocked 10-line-to-BCD encoder, the inverse of the one-of-ten decimal decoder.
- Accepts ten active-low decimal lines from a keypad or selector and synchronizes them.
- Priority-encodes the lines, with line 9 highest, then debounces the result.
- Presents one accepted BCD code per key press, with a valid/ack handshake and overrun flag.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronized cycles required to accept a press or a release; legal range >= 1.
- DELAY_RISE, 0: rise delay applied to all outputs, in the codebase's usual output-delay form.
- DELAY_FALL, 0: fall delay applied to all outputs.

Ports:
- Clk  input  1  rising-edge clock
- Clear_bar  input  1  asynchronous active-low reset
- D_bar  input  10  decimal lines, active low; bit n low = digit n requested
- Ack  input  1  consumer acknowledge; clears Valid and Overrun
- Q  output  4  last accepted BCD code
- Valid  output  1  an accepted code is pending
- Overrun  output  1  sticky; a code was accepted while a previous code was unacknowledged
- Pressed  output  1  a key is currently accepted and not yet debounced-released

Behaviour:
- Interface: one clock, Clk; reset Clear_bar is asynchronous and active-low.
- Reset (Clear_bar low, any time including mid-debounce): Q=0000, Valid=0, Overrun=0, Pressed=0, state=IDLE, counter=0, both sync stages=10'h3FF.
- Synchronizer: two flops on D_bar; the FSM sees only the second stage, sD.
- Encoder (combinational on sD): any = |~sD; code = index of the highest-numbered low bit; code=0000 when any=0.
- Counter width: $clog2(DEBOUNCE_CYCLES+1).
- FSM states and transitions:
  - IDLE: if any, go to DEBOUNCE with cand<=code and cnt<=1.
  - DEBOUNCE: if !any or code!=cand, go to IDLE and set cnt<=0. Else if cnt==DEBOUNCE_CYCLES, accept and go to HELD. Else cnt++.
  - HELD: if !any, go to RELEASE with cnt<=1. A code change while any=1 is ignored: no rollover, and a full release is required before the next press.
  - RELEASE: if any, return to HELD with no new accept. Else if cnt==DEBOUNCE_CYCLES, go to IDLE. Else cnt++.
- Accept action:
  - Q<=cand and Valid<=1.
  - If Valid=1 and Ack=0 in the same cycle, also set Overrun<=1. Q is overwritten, so the newest code wins.
  - If Ack=1 in the same cycle, Valid stays 1 and Overrun is unchanged.
- Ack with no accept that cycle: Valid<=0 and Overrun<=0. Ack when Valid=0 is harmless.
- Pressed = 1 in HELD or RELEASE.
- Latency: D_bar stable before edge E0 gives Valid, Q and Pressed updated after edge E0+DEBOUNCE_CYCLES+2. With the default of 4, that is after E0+6.
- Release latency: IDLE reached, and Pressed=0, after edge E0+DEBOUNCE_CYCLES+2 from an all-high input.
- Q holds its value after release until the next accept.
- All outputs are registered; no output depends combinationally on inputs.

Decomposition:
- Shared include with the FSM state localparams: IDLE=2'd0, DEBOUNCE=2'd1, HELD=2'd2, RELEASE=2'd3.
- One combinational sub-module, ttl_priority_encoder_10to4: in[9:0] active-low, outputs code[3:0] and any.
- The top level holds the synchronizer, FSM, counter and handshake registers.

Test Plan:
- Reset: Clear_bar=0 with D_bar=10'b1111011111 applied → Q=0000, Valid=0, Overrun=0, Pressed=0. Release reset: Valid rises only after edge E0+6.
- Single key: D_bar=10'b1111011111 (digit 5) held for 12 cycles → Q=0101 and Valid=1 after E0+6, Pressed=1. Pulse Ack → Valid=0 and Q stays 0101.
- Priority: digits 3 and 7 low (10'b1101110111) → Q=0111. Then release digit 7 while 3 is held → no new Valid (HELD ignores the change).
- Bounce: digit 2 low for 3 cycles, then all high → Valid stays 0, Pressed stays 0, FSM back in IDLE. Release glitch: in HELD, 2 high cycles then low again → no second Valid.
- Overrun: accept digit 1 (no Ack), release ≥ 6 cycles, press digit 8 → Q=1000, Valid=1, Overrun=1. Ack → Valid=0, Overrun=0. Ack coinciding with the accept edge → Valid=1, Overrun=0.
- Mid-operation reset: assert Clear_bar during DEBOUNCE of digit 9 → outputs zero immediately. Deassert with digit 9 still held → full re-debounce, Q=1001 after E0+6 from deassertion.

Source files
------------

// File: rtl/ttl_decimal_keypad_encoder_pkg.sv
// Shared FSM state encoding and constants for the decimal keypad encoder.
// Used by both the top level and the bench.
package ttl_decimal_keypad_encoder_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam int          NUM_LINES = 10;
  localparam logic [9:0]  SYNC_IDLE = 10'h3FF;

endpackage

// File: rtl/ttl_priority_encoder_10to4.sv
// Combinational 10-line active-low priority encoder; line 9 wins.
// Reports code 0 when no line is asserted.
module ttl_priority_encoder_10to4 (
  input  logic [9:0] in,
  output logic [3:0] code,
  output logic       any
);

  always_comb begin
    code = 4'd0;
    any  = ~&in;
    // Ascending scan so the highest-numbered asserted line is the last write.
    for (int i = 0; i < 10; i++) begin
      if (!in[i]) code = 4'(i);
    end
  end

endmodule

// File: rtl/ttl_decimal_keypad_encoder.sv
// Clocked 10-line-to-BCD keypad encoder: synchronizer, priority encode,
// press/release debounce FSM, and a valid/ack output handshake with overrun.
module ttl_decimal_keypad_encoder
  import ttl_decimal_keypad_encoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DELAY_RISE      = 0,
  parameter int DELAY_FALL      = 0
) (
  input  logic       Clk,
  input  logic       Clear_bar,
  input  logic [9:0] D_bar,
  input  logic       Ack,
  output logic [3:0] Q,
  output logic       Valid,
  output logic       Overrun,
  output logic       Pressed,
  output logic [1:0] o_dbg_state
);

  // Handshake: Valid rises on each accepted press and holds until an Ack
  // cycle with no simultaneous accept. An accept while Valid is already set
  // and not acknowledged that cycle sets sticky Overrun; the newest Q wins.

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  // Output delays are zero-time in hardware; only their legality is checked.
  generate
    if (DEBOUNCE_CYCLES < 1 || DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_bad_param
      $error("ttl_decimal_keypad_encoder: illegal parameter value");
    end
  endgenerate

  logic [9:0]       r_sync1;
  logic [9:0]       r_sync2;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [3:0]       r_cand;
  logic [3:0]       w_cand_nxt;
  logic             w_accept;
  logic [3:0]       w_code;
  logic             w_any;
  logic [3:0]       r_q;
  logic             r_valid;
  logic             r_overrun;
  logic             r_pressed;

  always_ff @(posedge Clk or negedge Clear_bar) begin
    if (!Clear_bar) begin
      r_sync1 <= SYNC_IDLE;
      r_sync2 <= SYNC_IDLE;
    end else begin
      r_sync1 <= D_bar;
      r_sync2 <= r_sync1;
    end
  end

  ttl_priority_encoder_10to4 u_enc (
    .in   (r_sync2),
    .code (w_code),
    .any  (w_any)
  );

  always_ff @(posedge Clk or negedge Clear_bar) begin
    if (!Clear_bar) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_cand  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cand  <= w_cand_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cand_nxt  = r_cand;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = DEBOUNCE;
          w_cand_nxt  = w_code;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      DEBOUNCE: begin
        if (!w_any || (w_code != r_cand)) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_MAX) begin
          w_accept    = 1'b1;
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      HELD: begin
        // Code changes while held are ignored; only a full release re-arms.
        if (!w_any) begin
          w_state_nxt = RELEASE;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      RELEASE: begin
        if (w_any) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_MAX) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Clear_bar) begin
    if (!Clear_bar) begin
      r_q       <= 4'd0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      r_pressed <= 1'b0;
    end else begin
      r_pressed <= (w_state_nxt == HELD) || (w_state_nxt == RELEASE);
      if (w_accept) begin
        r_q     <= r_cand;
        r_valid <= 1'b1;
        if (r_valid && !Ack) r_overrun <= 1'b1;
      end else if (Ack) begin
        r_valid   <= 1'b0;
        r_overrun <= 1'b0;
      end
    end
  end

  assign Q           = r_q;
  assign Valid       = r_valid;
  assign Overrun     = r_overrun;
  assign Pressed     = r_pressed;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ttl_decimal_keypad_encoder.sv
// Directed bench for the keypad encoder: a vector table of single presses
// plus hand-written sequences for bounce, glitch, overrun and reset cases.
module tb_ttl_decimal_keypad_encoder;
  import ttl_decimal_keypad_encoder_pkg::*;

  logic       Clk;
  logic       Clear_bar;
  logic [9:0] D_bar;
  logic       Ack;
  logic [3:0] Q;
  logic       Valid;
  logic       Overrun;
  logic       Pressed;
  logic [1:0] dbg_state;

  int n_total = 0;
  int n_pass  = 0;
  logic [3:0] exp_q[$];

  typedef struct {
    logic [9:0] d_bar;
    logic [3:0] exp_code;
    string      name;
  } vec_t;

  vec_t vecs[6];

  ttl_decimal_keypad_encoder #(.DEBOUNCE_CYCLES(4)) dut (
    .Clk         (Clk),
    .Clear_bar   (Clear_bar),
    .D_bar       (D_bar),
    .Ack         (Ack),
    .Q           (Q),
    .Valid       (Valid),
    .Overrun     (Overrun),
    .Pressed     (Pressed),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // driver tasks
  task automatic edges(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Press from IDLE: no accept through E0+5, accept visible after E0+6.
  task automatic press(input logic [9:0] d, input logic [3:0] code, input string name);
    D_bar = d;
    edges(6);
    check({name, "_pressed_early"}, Pressed, 1'b0);
    edges(1);
    exp_q.push_back(code);
    check({name, "_q"}, Q, exp_q.pop_front());
    check({name, "_valid"}, Valid, 1'b1);
    check({name, "_pressed"}, Pressed, 1'b1);
  endtask

  task automatic ack_pulse(input string name, input logic [3:0] q_keep);
    Ack = 1'b1;
    edges(1);
    Ack = 1'b0;
    check({name, "_ack_valid"}, Valid, 1'b0);
    check({name, "_ack_overrun"}, Overrun, 1'b0);
    check({name, "_ack_q"}, Q, q_keep);
  endtask

  task automatic release_all(input string name);
    D_bar = 10'h3FF;
    edges(6);
    check({name, "_rel_pressed_early"}, Pressed, 1'b1);
    edges(1);
    check({name, "_rel_pressed"}, Pressed, 1'b0);
    check({name, "_rel_state"}, dbg_state, 2'(IDLE));
  endtask

  initial begin
    vecs[0] = '{10'b1111111110, 4'd0, "digit0"};
    vecs[1] = '{10'b0111111111, 4'd9, "digit9"};
    vecs[2] = '{10'b1101110111, 4'd7, "digits3_7"};
    vecs[3] = '{10'b0000000000, 4'd9, "all_low"};
    vecs[4] = '{10'b1111111100, 4'd1, "digits0_1"};
    vecs[5] = '{10'b1011111111, 4'd8, "digit8"};

    Clear_bar = 1'b0;
    Ack       = 1'b0;
    D_bar     = 10'b1111011111;

    // reset holds everything at zero even with a key down
    #12;
    check("rst_q", Q, 4'd0);
    check("rst_valid", Valid, 1'b0);
    check("rst_overrun", Overrun, 1'b0);
    check("rst_pressed", Pressed, 1'b0);
    check("rst_state", dbg_state, 2'(IDLE));

    // single key released from reset, held 12 cycles
    @(posedge Clk);
    #1;
    Clear_bar = 1'b1;
    press(10'b1111011111, 4'd5, "key5");
    edges(5);
    check("key5_hold_valid", Valid, 1'b1);
    check("key5_hold_state", dbg_state, 2'(HELD));
    ack_pulse("key5", 4'd5);
    release_all("key5");
    check("key5_q_after_release", Q, 4'd5);

    // table of single presses
    for (int i = 0; i < 6; i++) begin
      press(vecs[i].d_bar, vecs[i].exp_code, vecs[i].name);
      ack_pulse(vecs[i].name, vecs[i].exp_code);
      release_all(vecs[i].name);
    end

    // priority, then drop digit 7 while 3 stays down: no new accept
    press(10'b1101110111, 4'd7, "prio");
    ack_pulse("prio", 4'd7);
    D_bar = 10'b1111110111;
    edges(10);
    check("prio_change_valid", Valid, 1'b0);
    check("prio_change_q", Q, 4'd7);
    check("prio_change_pressed", Pressed, 1'b1);
    release_all("prio");

    // press bounce: 3 cycles low is too short
    D_bar = 10'b1111111011;
    edges(3);
    D_bar = 10'h3FF;
    edges(10);
    check("bounce_valid", Valid, 1'b0);
    check("bounce_pressed", Pressed, 1'b0);
    check("bounce_state", dbg_state, 2'(IDLE));
    check("bounce_q", Q, 4'd7);

    // release glitch: 2 high cycles while held
    press(10'b1111101111, 4'd4, "glitch");
    ack_pulse("glitch", 4'd4);
    D_bar = 10'h3FF;
    edges(2);
    D_bar = 10'b1111101111;
    edges(12);
    check("glitch_valid", Valid, 1'b0);
    check("glitch_pressed", Pressed, 1'b1);
    check("glitch_state", dbg_state, 2'(HELD));
    release_all("glitch");

    // overrun: second accept without ack
    press(10'b1111111101, 4'd1, "ovr1");
    check("ovr1_overrun", Overrun, 1'b0);
    release_all("ovr1");
    press(10'b1011111111, 4'd8, "ovr8");
    check("ovr8_overrun", Overrun, 1'b1);
    ack_pulse("ovr8", 4'd8);
    release_all("ovr8");

    // ack on the accept edge: valid stays, overrun not set
    press(10'b1110111111, 4'd6, "ackco6");
    release_all("ackco6");
    D_bar = 10'b1111111011;
    edges(6);
    check("ackco_pre_valid", Valid, 1'b1);
    check("ackco_pre_q", Q, 4'd6);
    Ack = 1'b1;
    edges(1);
    Ack = 1'b0;
    check("ackco_valid", Valid, 1'b1);
    check("ackco_overrun", Overrun, 1'b0);
    check("ackco_q", Q, 4'd2);
    ack_pulse("ackco", 4'd2);
    release_all("ackco");

    // reset in the middle of a debounce, then a full re-debounce
    D_bar = 10'b0111111111;
    edges(3);
    check("midrst_state_deb", dbg_state, 2'(DEBOUNCE));
    #2;
    Clear_bar = 1'b0;
    #1;
    check("midrst_q", Q, 4'd0);
    check("midrst_valid", Valid, 1'b0);
    check("midrst_state", dbg_state, 2'(IDLE));
    @(posedge Clk);
    #1;
    Clear_bar = 1'b1;
    edges(6);
    check("midrst_valid_early", Valid, 1'b0);
    check("midrst_q_early", Q, 4'd0);
    edges(1);
    check("midrst_q9", Q, 4'd9);
    check("midrst_valid9", Valid, 1'b1);
    check("midrst_pressed9", Pressed, 1'b1);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
